// File: rtl/dpram_responder.sv
// Strobe-driven responder wrapping a synchronous 2^ADDR_W x DATA_W array.
// Optional macro DPRAM_PARITY_EN adds a stored parity bit and the Par_Err output.
module dpram_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              ar,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DIn,
  input  logic              RD,
  input  logic              WR,
  output logic [DATA_W-1:0] DOut,
  output logic              Done,
  output logic              Busy,
`ifdef DPRAM_PARITY_EN
  output logic              Req_Drop,
  output logic              Par_Err
`else
  output logic              Req_Drop
`endif
);

`ifdef DPRAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [2:0]  CNT_LAST = 3'(WAIT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              op_wr_q, op_wr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              rd_rise, wr_rise, req;
  logic              mem_we;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word;
`ifdef DPRAM_PARITY_EN
  logic              par_q, par_d;
`endif

  logic [MEM_W-1:0] mem [DEPTH];

  assign rd_rise = RD & ~rd_q;
  assign wr_rise = WR & ~wr_q;
  assign req     = rd_rise | wr_rise;
  assign rd_word = mem[addr_q];

`ifdef DPRAM_PARITY_EN
  assign mem_wdata = {^data_q, data_q};
`else
  assign mem_wdata = data_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_wr_d = op_wr_q;
    dout_d  = dout_q;
    done_d  = done_q;
    busy_d  = busy_q;
    drop_d  = drop_q;
    mem_we  = 1'b0;
`ifdef DPRAM_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = A;
          data_d  = DIn;
          // A simultaneous read edge is dropped silently in favour of the write.
          op_wr_d = wr_rise;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) state_d = StAccess;
      end
      StAccess: begin
        if (op_wr_q) begin
          mem_we = 1'b1;
        end else begin
          dout_d = rd_word[DATA_W-1:0];
`ifdef DPRAM_PARITY_EN
          par_d  = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`endif
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (req && (state_q != StIdle)) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      op_wr_q <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
`ifdef DPRAM_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= RD;
      wr_q    <= WR;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_wr_q <= op_wr_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
`ifdef DPRAM_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Array is deliberately not reset; mem_we is only raised in a live ACCESS state.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
  end

  assign DOut     = dout_q;
  assign Done     = done_q;
  assign Busy     = busy_q;
  assign Req_Drop = drop_q;
`ifdef DPRAM_PARITY_EN
  assign Par_Err  = par_q;
`endif

endmodule

// File: tb/tb_dpram_responder.sv
// Self-checking bench for dpram_responder: directed cases plus randomized strobes
// checked every cycle against a cycle-count based reference model.
module tb_dpram_responder;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = 2;

  logic          clk = 1'b0;
  logic          ar  = 1'b0;
  logic [AW-1:0] A   = '0;
  logic [DW-1:0] DIn = '0;
  logic          RD  = 1'b0;
  logic          WR  = 1'b0;
  logic [DW-1:0] DOut;
  logic          Done, Busy, Req_Drop;
`ifdef DPRAM_PARITY_EN
  logic          Par_Err;
`endif

  int tests = 0;
  int fails = 0;

  dpram_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W)) dut (
    .clk      (clk),
    .ar       (ar),
    .A        (A),
    .DIn      (DIn),
    .RD       (RD),
    .WR       (WR),
    .DOut     (DOut),
    .Done     (Done),
    .Busy     (Busy),
`ifdef DPRAM_PARITY_EN
    .Req_Drop (Req_Drop),
    .Par_Err  (Par_Err)
`else
    .Req_Drop (Req_Drop)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request completes a fixed W+1 cycles after capture.
  logic [DW-1:0] mem_m [1 << AW];
  logic          m_prev_rd, m_prev_wr, m_pend, m_pw;
  logic [AW-1:0] m_pa;
  logic [DW-1:0] m_pd, m_dout;
  logic          m_done, m_busy, m_drop;
  int            cyc = 0;
  int            m_due;

  initial forever begin
    @(posedge clk or negedge ar);
    if (!ar) begin
      m_prev_rd = 1'b0; m_prev_wr = 1'b0; m_pend = 1'b0;
      m_dout = '0; m_done = 1'b0; m_busy = 1'b0; m_drop = 1'b0;
    end else begin
      logic rr, ww, was;
      rr  = RD & ~m_prev_rd;
      ww  = WR & ~m_prev_wr;
      was = m_pend;
      if (m_pend && cyc == m_due) begin
        if (m_pw) mem_m[m_pa] = m_pd;
        else      m_dout = mem_m[m_pa];
        m_done = 1'b1; m_busy = 1'b0; m_pend = 1'b0;
      end
      if (rr || ww) begin
        if (was) m_drop = 1'b1;
        else begin
          m_pw = ww; m_pa = A; m_pd = DIn; m_pend = 1'b1;
          m_due = cyc + W + 1; m_done = 1'b0; m_busy = 1'b1;
        end
      end
      m_prev_rd = RD;
      m_prev_wr = WR;
      cyc++;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (ar && chk_en) begin
      chk("model_dout", 32'(DOut), 32'(m_dout));
      chk("model_done", 32'(Done), 32'(m_done));
      chk("model_busy", 32'(Busy), 32'(m_busy));
      chk("model_drop", 32'(Req_Drop), 32'(m_drop));
`ifdef DPRAM_PARITY_EN
      chk("model_par_err", 32'(Par_Err), 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    RD = 1'b0; WR = 1'b0;
    ar = 1'b0;
    tick(); tick();
    ar = 1'b1;
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    A = a; DIn = d; WR = 1'b1;
    tick();
    WR = 1'b0;
    repeat (W + 1) tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    A = a; RD = 1'b1;
    tick();
    RD = 1'b0;
    repeat (W + 1) tick();
  endtask

  logic [AW-1:0] pool [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    chk("reset_dout", 32'(DOut), 32'h0);
    chk("reset_done", 32'(Done), 32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);
    chk("reset_drop", 32'(Req_Drop), 32'h0);
    ar = 1'b1;
    tick();
    chk_en = 1'b1;

    // Basic write then held read with exact Done timing.
    A = 10'h005; DIn = 16'h0ABC; WR = 1'b1;
    tick();
    WR = 1'b0;
    tick(); tick();
    chk("wr_done_early", 32'(Done), 32'h0);
    tick();
    chk("wr_done_k3", 32'(Done), 32'h1);
    A = 10'h005; RD = 1'b1;
    tick(); tick(); tick();
    chk("rd_done_early", 32'(Done), 32'h0);
    tick();
    chk("rd_done_k3", 32'(Done), 32'h1);
    chk("rd_dout", 32'(DOut), 32'h0ABC);
    repeat (4) tick();
    RD = 1'b0;
    tick();
    chk("rd_held_done", 32'(Done), 32'h1);

    // Boundary addresses.
    do_write(10'h3FF, 16'h1111);
    do_write(10'h000, 16'h2222);
    do_read(10'h3FF);
    chk("bound_3ff", 32'(DOut), 32'h1111);
    do_read(10'h000);
    chk("bound_000", 32'(DOut), 32'h2222);

    // Simultaneous edges: write wins, DOut untouched, no drop.
    do_read(10'h005);
    A = 10'h010; DIn = 16'hBEEF; RD = 1'b1; WR = 1'b1;
    tick();
    RD = 1'b0; WR = 1'b0;
    repeat (W + 1) tick();
    chk("simul_dout", 32'(DOut), 32'h0ABC);
    chk("simul_drop", 32'(Req_Drop), 32'h0);
    do_read(10'h010);
    chk("simul_readback", 32'(DOut), 32'hBEEF);

    // Busy collision.
    do_write(10'h030, 16'h3333);
    do_write(10'h040, 16'h4444);
    A = 10'h030; RD = 1'b1;
    tick();
    RD = 1'b0; A = 10'h040; DIn = 16'hDEAD; WR = 1'b1;
    tick();
    WR = 1'b0;
    repeat (W) tick();
    chk("coll_drop", 32'(Req_Drop), 32'h1);
    chk("coll_read", 32'(DOut), 32'h3333);
    chk("coll_done", 32'(Done), 32'h1);
    do_read(10'h040);
    chk("coll_target", 32'(DOut), 32'h4444);
    do_reset();

    // Reset mid-write.
    do_write(10'h020, 16'h1234);
    A = 10'h020; DIn = 16'h5678; WR = 1'b1;
    tick();
    WR = 1'b0;
    chk("midrst_busy_pre", 32'(Busy), 32'h1);
    #2 ar = 1'b0;
    #1;
    chk("midrst_dout", 32'(DOut), 32'h0);
    chk("midrst_done", 32'(Done), 32'h0);
    chk("midrst_busy", 32'(Busy), 32'h0);
    chk("midrst_drop", 32'(Req_Drop), 32'h0);
    tick();
    ar = 1'b1;
    tick();
    do_read(10'h020);
    chk("midrst_readback", 32'(DOut), 32'h1234);
    do_reset();

    // Held strobe: one Busy pulse of W+1 cycles.
    begin
      int ones, rises;
      logic prev;
      ones = 0; rises = 0; prev = 1'b0;
      A = 10'h020; RD = 1'b1;
      repeat (20) begin
        tick();
        if (Busy) ones++;
        if (Busy && !prev) rises++;
        prev = Busy;
      end
      RD = 1'b0;
      tick();
      chk("held_busy_cycles", 32'(ones), 32'(W + 1));
      chk("held_busy_pulses", 32'(rises), 32'd1);
      chk("held_drop", 32'(Req_Drop), 32'h0);
      chk("held_dout", 32'(DOut), 32'h1234);
    end

    // Randomized strobes over a preloaded address pool.
    for (int i = 0; i < 16; i++) pool[i] = 10'($urandom);
    pool[0] = 10'h000;
    pool[1] = 10'h3FF;
    for (int i = 0; i < 16; i++) do_write(pool[i], 16'($urandom));
    for (int i = 0; i < 500; i++) begin
      RD  = ($urandom % 3) == 0;
      WR  = ($urandom % 4) == 0;
      A   = pool[$urandom % 16];
      DIn = 16'($urandom);
      tick();
    end
    RD = 1'b0; WR = 1'b0;
    repeat (W + 3) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dpram_responder.md
Name: dpram_responder

Overview:
- Memory-side responder for the internal DPRAM strobe interface. Test/IO controllers drive A, DIn, RD and WR into this block; it drives DOut and Done back to them.
- Wraps a 2^ADDR_W x DATA_W synchronous array.
- Converts level strobes into single accesses using rising-edge detection and a programmable wait-state counter.
- Reports completion on Done.

Parameters:
- ADDR_W, 10, address width; array depth is 2^ADDR_W words.
- DATA_W, 16, data word width.
- WAIT_CYC, 2, wait states between request capture and access; legal range 1..7.

Ports:
- clk  input  1  system clock; all logic on posedge.
- ar  input  1  asynchronous active-low reset.
- A  input  ADDR_W  access address, sampled on request edge.
- DIn  input  DATA_W  write data, sampled on request edge.
- RD  input  1  read strobe, level; a rising edge requests one read.
- WR  input  1  write strobe, level; a rising edge requests one write.
- DOut  output  DATA_W  read data; holds the last read result.
- Done  output  1  high from access completion until the next accepted request.
- Busy  output  1  high while a request is in flight.
- Req_Drop  output  1  sticky; set when a request edge arrives while Busy.

Behaviour:
- Reset:
  - One clock; reset is asynchronous, active-low on ar.
  - On ar low: DOut=0, Done=0, Busy=0, Req_Drop=0, state=IDLE, strobe history regs=0, wait counter=0.
  - Array contents are not reset.
- Edge detect:
  - rd_q and wr_q hold the previous-cycle RD and WR.
  - rd_rise = RD & ~rd_q; wr_rise = WR & ~wr_q.
  - A strobe held high produces exactly one request.
- States: IDLE, WAIT, ACCESS.
  - IDLE, on rd_rise or wr_rise at posedge k:
    - Latch A and DIn, and op=write if wr_rise, else read.
    - Done<=0, Busy<=1, cnt<=0, go to WAIT.
  - WAIT:
    - cnt increments each cycle.
    - When cnt==WAIT_CYC-1, go to ACCESS.
  - ACCESS:
    - Write: mem[addr]<=data, DOut unchanged.
    - Read: DOut<=mem[addr].
    - Done<=1, Busy<=0, go to IDLE.
- Latency:
  - Done rises, and read DOut is valid, at posedge k+WAIT_CYC+1 (default k+3).
  - The next request is accepted at k+WAIT_CYC+2 at the earliest.
- Simultaneous rd_rise and wr_rise in IDLE: write only; the read is discarded without setting Req_Drop.
- Any rd_rise or wr_rise while Busy: ignored, Req_Drop<=1 (stays 1 until reset). Edge history still updates, so a strobe held through Busy does not retrigger.
- Address wrap: none internal. A is used as given; 0 and 2^ADDR_W-1 are distinct words.
- Reset mid-operation:
  - Before ACCESS, the pending write is not committed and the pending read does not update DOut.
  - Both return to IDLE with reset values.
- Done stays high indefinitely in IDLE after completion.

Optional Feature:
- Macro: DPRAM_PARITY_EN.
- Defined:
  - Array width becomes DATA_W+1; the extra bit stores even parity (XOR) of the data on write.
  - On read in ACCESS, recomputed parity is compared against the stored bit.
  - Added output Par_Err (1 bit, reset 0) is updated on every read completion: 1 on mismatch, 0 otherwise. Writes do not change it.
- Undefined: no extra storage, no Par_Err port, behaviour otherwise identical.

Test Plan:
- Basic write/read, WAIT_CYC=2:
  - WR pulse (1 cycle) with A=0x005, DIn=0x0ABC; then RD held high for 8 cycles with A=0x005.
  - Required: Done=1 exactly 3 cycles after each edge, DOut=0x0ABC.
- Boundary addresses:
  - Write 0x1111 at 0x3FF and 0x2222 at 0x000.
  - Read both back: required 0x1111 and 0x2222, no aliasing.
- Simultaneous edges:
  - RD and WR rise in the same cycle with A=0x010, DIn=0xBEEF, while DOut=0x0ABC.
  - Required: DOut stays 0x0ABC, Req_Drop=0; a later read of 0x010 returns 0xBEEF.
- Busy collision:
  - Issue a read, then a WR edge one cycle later.
  - Required: Req_Drop=1, the target word is unchanged, and the read completes normally.
- Reset mid-write:
  - Preload 0x1234 at 0x020, then issue a write of 0x5678 to 0x020.
  - Pull ar low 1 cycle after the edge.
  - Required: all outputs return to 0 immediately; a subsequent read of 0x020 returns 0x1234.
- Held strobe:
  - RD held high for 20 cycles.
  - Required: exactly one Busy pulse of WAIT_CYC+1 cycles and Req_Drop=0.
  - With DPRAM_PARITY_EN defined: Par_Err=0 on every clean read.
